mux21_rr_arbiter: RTL and testbench
===================================

# mux21_rr_arbiter

Round-robin arbiter and sequencer for the 2-bit 2:1 multiplexer path. Two requesters each present a 2-bit beat with a valid/ready handshake. The block grants one lane per beat, drives the mux select, and captures the selected beat into a single output register with downstream backpressure. A per-owner burst limit bounds how long one lane can hold the mux while the other lane is waiting.

## Interface
- WIDTH, 2, data width per lane
- BURST_LEN, 4, max consecutive beats one lane may take while the other is requesting; legal range 1..15
- clk  input  1  rising-edge clock, sole clock domain
- reset  input  1  synchronous, active-high reset, sampled on posedge clk
- data_in0  input  WIDTH  lane 0 beat
- valid_in0  input  1  lane 0 beat present
- ready_in0  output  1  lane 0 beat accepted this cycle (combinational)
- data_in1  input  WIDTH  lane 1 beat
- valid_in1  input  1  lane 1 beat present
- ready_in1  output  1  lane 1 beat accepted this cycle (combinational)
- selector  output  1  current grant, drives mux select; 0 = lane 0 (combinational)
- data_out  output  WIDTH  registered selected beat
- valid_out  output  1  data_out holds an unconsumed beat
- ready_out  input  1  downstream consumes data_out when valid_out=1
- lane_out  output  1  source lane of the beat in data_out

## Operation
- State register: IDLE, OWN0, OWN1. Side registers:
  - last: lane of the most recent transfer; reset value 1, so lane 0 wins the first tie.
  - cnt: 4 bits, counts consecutive beats of the current owner; saturates at 15.
- can_accept = !valid_out || ready_out. Output register is load-through, with no bubble when draining.
- Grant, combinational, with x = owner and y = other lane:
  - IDLE, both valid: grant the lane != last.
  - IDLE, one valid: grant that lane.
  - OWNx: grant x if valid_inx && (cnt < BURST_LEN || !valid_iny).
  - OWNx otherwise: grant y if valid_iny, else no grant.
- selector = granted lane. With no grant, selector holds last.
- ready_ing = can_accept && grant==g. Both readies are never high together.
- Transfer on lane g (valid_ing && ready_ing):
  - data_out <= data_ing, lane_out <= g, valid_out <= 1, last <= g, state <= OWNg.
  - cnt <= (state==OWNg) ? sat(cnt+1) : 1.
- can_accept with no grant: state <= IDLE, cnt <= 0. If ready_out=1, valid_out <= 0.
- !can_accept: state, cnt, last and the output register all hold. Grant is still computed but no ready is asserted.
- Lane switch caused by burst expiry moves ownership to y with cnt=1. x can regain ownership only after y's burst expires or y goes idle.
- Inputs must hold valid/data until ready. The block does not check this.

## Timing
- Reset (synchronous, 1 cycle min) clears:
  - state=IDLE, cnt=0, last=1
  - valid_out=0, data_out=0, lane_out=0
  - ready_in0/1=0 while reset is high; selector=1 while reset is high (last=1)
- Reset mid-operation: any beat in data_out is dropped and no input is accepted in the reset cycle.
- Latency: input transfer at edge N, so data_out/valid_out are valid after edge N. Sustained throughput is 1 beat/cycle with ready_out held high.
- Simultaneous drain and load: when valid_out=1 and ready_out=1 and a grant occurs, the old beat is consumed and the new beat is loaded on the same edge.
- BURST_LEN=1 with both lanes always valid gives strict alternation 0,1,0,1.
- cnt saturation at 15 matters only when the other lane is idle; no wrap.

## Structure
- Package mux21_arb_pkg holds:
  - state enum (IDLE, OWN0, OWN1)
  - CNT_W=4
  - default WIDTH/BURST_LEN constants
- Sub-module mux21_arb_grant: purely combinational grant logic. Inputs are state, cnt, last and both valids; outputs are grant_valid and grant_lane. The top level holds the registers and the datapath select.

## Test plan
- Reset then both valid constantly, data0=2'b01, data1=2'b10, BURST_LEN=4, ready_out=1 -> lane_out sequence 0,0,0,0,1,1,1,1,0… and data_out follows 01/10 accordingly.
- Only valid_in1 high for 20 cycles -> every beat from lane 1, ready_in0=0 throughout, cnt saturates at 15 with no switch and no stall.
- Beat loaded, then ready_out=0 for 3 cycles -> data_out and lane_out hold, ready_in0/1=0, selector is stable; transfer resumes on the cycle ready_out rises.
- First cycle after reset with both valid -> lane 0 granted (last=1). After lane 0 drops valid for 1 cycle (IDLE) and both return, lane 1 is granted.
- Assert reset while valid_out=1 with a pending burst -> next cycle valid_out=0, data_out=0, state IDLE; the first beat after release follows the last=1 rule.
- BURST_LEN=1, both valid, ready_out toggling 1,0,1,0 -> strict alternation of lanes across accepted beats, and no beat is lost or duplicated (scoreboard check).

Source files
------------

// File: rtl/mux21_arb_pkg.sv
// Shared types and constants for the 2:1 round-robin mux arbiter.
package mux21_arb_pkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam int CNT_W         = 4;
   localparam int CNT_MAX       = 15;
   localparam int DEF_WIDTH     = 2;
   localparam int DEF_BURST_LEN = 4;
endpackage

// File: rtl/mux21_rr_arbiter_if.sv
// Two-lane request bus plus registered output channel of the arbiter.
interface mux21_rr_arbiter_if #(parameter int WIDTH = 2);
   logic [WIDTH-1:0] data_in0;
   logic             valid_in0;
   logic             ready_in0;
   logic [WIDTH-1:0] data_in1;
   logic             valid_in1;
   logic             ready_in1;
   logic             selector;
   logic [WIDTH-1:0] data_out;
   logic             valid_out;
   logic             ready_out;
   logic             lane_out;

   modport master (
      output data_in0, valid_in0, data_in1, valid_in1, ready_out,
      input  ready_in0, ready_in1, selector, data_out, valid_out, lane_out
   );

   modport slave (
      input  data_in0, valid_in0, data_in1, valid_in1, ready_out,
      output ready_in0, ready_in1, selector, data_out, valid_out, lane_out
   );
endinterface

// File: rtl/mux21_arb_grant.sv
// Combinational lane choice: round-robin tie break from IDLE, burst-limited
// ownership otherwise.
module mux21_arb_grant
   import mux21_arb_pkg::*;
#(
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input  state_t           state,
   input  logic [CNT_W-1:0] cnt,
   input  logic             last,
   input  logic [1:0]       valid,
   output logic             grant_valid,
   output logic             grant_lane
);
   localparam logic [CNT_W-1:0] BL = CNT_W'(BURST_LEN);

   logic owner;

   always_comb begin
      grant_valid = 1'b0;
      grant_lane  = 1'b0;
      owner       = (state == OWN1);
      case (state)
         IDLE: begin
            if (&valid) begin
               grant_valid = 1'b1;
               grant_lane  = ~last;
            end else if (|valid) begin
               grant_valid = 1'b1;
               grant_lane  = valid[1];
            end
         end
         OWN0, OWN1: begin
            // Owner keeps the mux until its burst expires, unless the other lane is idle
            if (valid[owner] && ((cnt < BL) || !valid[~owner])) begin
               grant_valid = 1'b1;
               grant_lane  = owner;
            end else if (valid[~owner]) begin
               grant_valid = 1'b1;
               grant_lane  = ~owner;
            end
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/mux21_rr_arbiter.sv
// Round-robin 2:1 arbiter with a load-through output register and
// per-owner burst limit.
module mux21_rr_arbiter
   import mux21_arb_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int BURST_LEN = DEF_BURST_LEN
) (
   input logic              clk,
   input logic              reset,
   mux21_rr_arbiter_if.slave bus
);
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_q, last_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             vout_q, vout_d;
   logic             lane_q, lane_d;

   logic [1:0][WIDTH-1:0] data_in;
   logic                  grant_valid, grant_lane, can_accept;
   state_t                own_d;

   assign data_in    = {bus.data_in1, bus.data_in0};
   assign can_accept = !vout_q || bus.ready_out;

   mux21_arb_grant #(.BURST_LEN(BURST_LEN)) u_grant (
      .state       (state_q),
      .cnt         (cnt_q),
      .last        (last_q),
      .valid       ({bus.valid_in1, bus.valid_in0}),
      .grant_valid (grant_valid),
      .grant_lane  (grant_lane)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      dout_d  = dout_q;
      vout_d  = vout_q;
      lane_d  = lane_q;
      own_d   = grant_lane ? OWN1 : OWN0;
      if (can_accept) begin
         if (grant_valid) begin
            dout_d  = data_in[grant_lane];
            lane_d  = grant_lane;
            vout_d  = 1'b1;
            last_d  = grant_lane;
            state_d = own_d;
            if (state_q == own_d)
               cnt_d = (cnt_q == CNT_W'(CNT_MAX)) ? cnt_q : cnt_q + 1'b1;
            else
               cnt_d = CNT_W'(1);
         end else begin
            state_d = IDLE;
            cnt_d   = '0;
            if (bus.ready_out) vout_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         dout_q  <= '0;
         vout_q  <= 1'b0;
         lane_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         dout_q  <= dout_d;
         vout_q  <= vout_d;
         lane_q  <= lane_d;
      end
   end

   // Reset masks the handshake and parks the mux on lane 1 in the reset cycle itself
   assign bus.ready_in0 = !reset && can_accept && grant_valid && !grant_lane;
   assign bus.ready_in1 = !reset && can_accept && grant_valid &&  grant_lane;
   assign bus.selector  = reset ? 1'b1 : (grant_valid ? grant_lane : last_q);
   assign bus.data_out  = dout_q;
   assign bus.valid_out = vout_q;
   assign bus.lane_out  = lane_q;
endmodule

// File: tb/tb_mux21_rr_arbiter.sv
// Bench for mux21_rr_arbiter: two instances (burst 4 and burst 1) share stimulus
// and are checked every cycle against a behavioural arbitration model.
module tb_mux21_rr_arbiter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] d0 = '0, d1 = '0;
   logic       v0 = 1'b0, v1 = 1'b0, rdy = 1'b1;

   always #5 clk = ~clk;

   mux21_rr_arbiter_if #(.WIDTH(2)) bus4 ();
   mux21_rr_arbiter_if #(.WIDTH(2)) bus1 ();

   assign bus4.data_in0 = d0;  assign bus1.data_in0 = d0;
   assign bus4.data_in1 = d1;  assign bus1.data_in1 = d1;
   assign bus4.valid_in0 = v0; assign bus1.valid_in0 = v0;
   assign bus4.valid_in1 = v1; assign bus1.valid_in1 = v1;
   assign bus4.ready_out = rdy; assign bus1.ready_out = rdy;

   mux21_rr_arbiter #(.WIDTH(2), .BURST_LEN(4)) u4 (.clk(clk), .reset(reset), .bus(bus4.slave));
   mux21_rr_arbiter #(.WIDTH(2), .BURST_LEN(1)) u1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   logic       r0 [2], r1 [2], sel [2], vo [2], lo [2];
   logic [1:0] dout [2];
   assign r0[0] = bus4.ready_in0;  assign r0[1] = bus1.ready_in0;
   assign r1[0] = bus4.ready_in1;  assign r1[1] = bus1.ready_in1;
   assign sel[0] = bus4.selector;  assign sel[1] = bus1.selector;
   assign vo[0] = bus4.valid_out;  assign vo[1] = bus1.valid_out;
   assign lo[0] = bus4.lane_out;   assign lo[1] = bus1.lane_out;
   assign dout[0] = bus4.data_out; assign dout[1] = bus1.data_out;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: owner = -1 when no lane owns the mux; run = consecutive beats of owner
   int  bl [2] = '{4, 1};
   int  m_own [2], m_run [2], m_last [2], m_vo [2], m_do [2], m_lo [2];
   bit  model_on = 1'b0;
   bit  adv [2];
   logic [2:0] sbq [$];

   function automatic int grant_of(int k);
      bit va [2];
      int x;
      va[0] = v0; va[1] = v1;
      if (m_own[k] < 0) begin
         if (va[0] && va[1]) return 1 - m_last[k];
         if (va[0]) return 0;
         if (va[1]) return 1;
         return -1;
      end
      x = m_own[k];
      if (va[x] && (m_run[k] < bl[k] || !va[1-x])) return x;
      if (va[1-x]) return 1 - x;
      return -1;
   endfunction

   always @(negedge clk) begin
      int g, esel;
      bit ca;
      logic [2:0] b;
      for (int k = 0; k < 2; k++) begin
         g    = grant_of(k);
         ca   = (m_vo[k] == 0) || rdy;
         esel = reset ? 1 : (g >= 0 ? g : m_last[k]);
         if (model_on) begin
            chk($sformatf("ready_in0_bl%0d", bl[k]), r0[k], !reset && ca && g == 0);
            chk($sformatf("ready_in1_bl%0d", bl[k]), r1[k], !reset && ca && g == 1);
            chk($sformatf("selector_bl%0d", bl[k]), sel[k], esel);
            chk($sformatf("valid_out_bl%0d", bl[k]), vo[k], m_vo[k]);
            chk($sformatf("data_out_bl%0d", bl[k]), dout[k], m_do[k]);
            chk($sformatf("lane_out_bl%0d", bl[k]), lo[k], m_lo[k]);
            if (k == 1 && !reset && vo[1] && rdy) begin
               if (sbq.size() == 0) chk("sb_underflow_bl1", 1, 0);
               else begin
                  b = sbq.pop_front();
                  chk("sb_beat_bl1", {5'd0, lo[1], dout[1]}, {5'd0, b});
               end
            end
         end
         if (k == 1) begin adv[0] = 0; adv[1] = 0; end
         if (reset) begin
            m_own[k] = -1; m_run[k] = 0; m_last[k] = 1;
            m_vo[k] = 0; m_do[k] = 0; m_lo[k] = 0;
            if (k == 1) sbq.delete();
         end else if (ca) begin
            if (g >= 0) begin
               m_do[k]  = (g == 1) ? d1 : d0;
               m_lo[k]  = g;
               m_vo[k]  = 1;
               m_run[k] = (m_own[k] == g) ? ((m_run[k] < 15) ? m_run[k] + 1 : 15) : 1;
               m_own[k] = g;
               m_last[k] = g;
               if (k == 1) begin
                  sbq.push_back({g[0], (g == 1) ? d1 : d0});
                  adv[g] = 1;
               end
            end else begin
               m_own[k] = -1;
               m_run[k] = 0;
               if (rdy) m_vo[k] = 0;
            end
         end
      end
      if (reset) model_on = 1'b1;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      int exp4 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
      int prev;
      repeat (2) step();
      @(negedge clk);
      chk("rst_valid_out", bus4.valid_out, 0);
      chk("rst_selector", bus4.selector, 1);
      chk("rst_ready", {bus4.ready_in1, bus4.ready_in0}, 0);

      // Both lanes busy: burst of 4 then switch; burst 1 alternates
      step();
      reset = 0; v0 = 1; v1 = 1; d0 = 2'b01; d1 = 2'b10; rdy = 1;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("s1_lane_bl4_%0d", i), bus4.lane_out, exp4[i]);
         chk($sformatf("s1_data_bl4_%0d", i), bus4.data_out, exp4[i] ? 2 : 1);
         chk($sformatf("s1_lane_bl1_%0d", i), bus1.lane_out, i % 2);
      end

      // Lane 1 alone: never switches, never stalls
      step();
      v0 = 0; d1 = 2'b11;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); @(negedge clk);
         chk("s2_ready_in0", bus4.ready_in0, 0);
         chk("s2_ready_in1", bus4.ready_in1, 1);
         chk("s2_lane", bus4.lane_out, 1);
         chk("s2_valid", bus4.valid_out, 1);
      end

      // Backpressure: lane 0 beat held for 3 cycles
      step();
      v0 = 1; v1 = 1; d0 = 2'b10; d1 = 2'b01;
      @(posedge clk); #1;
      rdy = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("s3_hold_data", bus4.data_out, 2);
         chk("s3_hold_lane", bus4.lane_out, 0);
         chk("s3_ready", {bus4.ready_in1, bus4.ready_in0}, 0);
         chk("s3_selector", bus4.selector, 0);
         @(posedge clk);
      end
      #1 rdy = 1;
      @(negedge clk);
      chk("s3_resume", bus4.ready_in0, 1);

      // Reset with a beat pending, then round-robin from IDLE
      step();
      reset = 1;
      @(negedge clk);
      chk("s5_rst_ready_bl4", {bus4.ready_in1, bus4.ready_in0}, 0);
      chk("s5_rst_ready_bl1", {bus1.ready_in1, bus1.ready_in0}, 0);
      chk("s5_rst_sel", bus4.selector, 1);
      @(posedge clk); @(negedge clk);
      chk("s5_valid_out", bus4.valid_out, 0);
      chk("s5_data_out", bus4.data_out, 0);
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("s4_first_sel", bus4.selector, 0);
      chk("s4_first_ready0", bus4.ready_in0, 1);
      @(posedge clk); @(negedge clk);
      chk("s4_first_lane", bus4.lane_out, 0);
      @(posedge clk); #1;
      v0 = 0; v1 = 0;
      @(posedge clk); #1;
      v0 = 1; v1 = 1;
      @(negedge clk);
      chk("s4_rr_sel", bus4.selector, 1);
      chk("s4_rr_ready1", bus4.ready_in1, 1);

      // Burst 1, toggling downstream ready, inputs held until accepted
      prev = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         rdy = ~rdy;
         if (adv[0]) d0 = d0 + 2'd1;
         if (adv[1]) d1 = d1 + 2'd1;
         @(negedge clk);
         if (bus1.ready_in0 || bus1.ready_in1) begin
            if (prev >= 0) chk("s6_alternate", bus1.ready_in1, 1 - prev);
            prev = bus1.ready_in1;
         end
      end

      // Random traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         step();
         reset = ($urandom_range(0, 49) == 0);
         v0  = 1'($urandom);
         v1  = 1'($urandom);
         d0  = 2'($urandom);
         d1  = 2'($urandom);
         rdy = ($urandom_range(0, 3) != 0);
      end
      step();
      reset = 0; v0 = 0; v1 = 0; rdy = 1;
      repeat (4) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
